// File: rtl/led_red_fader.sv
// led_red_fader: turns the static red-LED port pattern into PWM drive.
// Each channel's brightness ramps linearly toward full on or full off, one
// step per prescaler tick. A shared free-running counter renders the PWM.
// bypass drives the pins straight from led_in and parks every level at its
// end point, so clearing bypass continues from there without a glitch.
module led_red_fader #(
  parameter int NUM_LEDS = 10,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic                bypass,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  // A one-bit prescaler is kept for STEP_DIV=1; it then stays at zero and ticks every cycle.
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
  // The PWM counter stops one short of all-ones, so LEVEL_MAX compares above every count.
  localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                step_tick;
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;
  logic [NUM_LEDS-1:0] unsettled;
  logic                busy_q, busy_d;

  assign step_tick = (presc_q == PRE_LAST);

  // Next values for the step prescaler, the PWM counter and the shared output flags.
  always_comb begin
    presc_d = step_tick ? '0 : presc_q + 1'b1;
    pwm_d   = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
    busy_d  = |unsettled;
  end

  // Counter and output registers; reset clears the pins immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_q     <= '0;
      led_out_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      led_out_q <= led_out_d;
      busy_q    <= busy_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
      logic [PWM_BITS-1:0] level_q, level_d;
      logic [PWM_BITS-1:0] target;

      assign target = led_in[gi] ? LEVEL_MAX : '0;

      // Saturating one-step ramp toward the target on each tick; bypass snaps to the end point.
      always_comb begin
        level_d = level_q;
        if (bypass) begin
          level_d = target;
        end else if (step_tick) begin
          if (led_in[gi] && (level_q != LEVEL_MAX)) begin
            level_d = level_q + 1'b1;
          end else if (!led_in[gi] && (level_q != '0)) begin
            level_d = level_q - 1'b1;
          end
        end
      end

      // Brightness level register for this channel.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          level_q <= '0;
        end else begin
          level_q <= level_d;
        end
      end

      assign led_out_d[gi] = bypass ? led_in[gi] : (level_q > pwm_q);
      // Settling is judged on the post-update level so busy drops with the final step.
      assign unsettled[gi] = (level_d != target);
    end
  endgenerate

  assign led_out = led_out_q;
  assign busy    = busy_q;

endmodule

// File: doc/led_red_fader.md
Name: led_red_fader

Overview:
- Downstream consumer of the 10-bit red-LED output-port register in system_0.
- Takes the static on/off pattern written by software and drives the physical LEDR pins.
- Each LED ramps its brightness up or down linearly in time instead of switching hard.
- Brightness is rendered with a shared PWM counter; an optional bypass restores direct on/off drive.

Parameters:
NUM_LEDS, 10, number of LED channels (matches port register width)
PWM_BITS, 8, brightness resolution; PWM period = 2^PWM_BITS-1 clocks
STEP_DIV, 50000, clocks between brightness steps (fade time = STEP_DIV*(2^PWM_BITS-1) clocks); must be >=1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
led_in  in  NUM_LEDS  target pattern from LED port register (1 = on)
bypass  in  1  1 = drive led_out directly from led_in, no fade/PWM
led_out  out  NUM_LEDS  PWM-modulated LED drive to pins (registered)
busy  out  1  1 while any channel level differs from its target (registered)

Behaviour:
- Reset (async, active-high):
  - All level[i] = 0, prescaler = 0, pwm_cnt = 0.
  - led_out = 0, busy = 0.
  - Reset asserted mid-fade abandons the fade immediately.
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps.
  - step_tick = 1 for one cycle when prescaler == STEP_DIV-1.
  - STEP_DIV=1 gives step_tick every cycle.
- PWM counter:
  - Free-running 0..2^PWM_BITS-2, then wraps to 0.
  - Period is 2^PWM_BITS-1 cycles, so level max (all ones) = always on and level 0 = always off.
- Per-channel level (PWM_BITS wide), updated only on step_tick:
  - led_in[i]=1 and level<max: level+1.
  - led_in[i]=0 and level>0: level-1.
  - Otherwise hold. Saturates: never wraps past max or below 0.
- Target reversal mid-ramp: the direction changes on the next step_tick from the current level; there is no jump.
- led_out[i] register:
  - bypass=0: led_out[i] <= (level[i] > pwm_cnt).
  - One-cycle latency from level/pwm_cnt to pin.
- bypass=1:
  - led_out[i] <= led_in[i] (1-cycle latency).
  - Every level[i] <= led_in[i] ? max : 0 each cycle, ignoring step_tick.
  - On bypass deassert, channels therefore continue at their settled level with no visible glitch.
- busy:
  - Register <= OR over i of (level[i] != (led_in[i] ? max : 0)), evaluated on the post-update level values.
  - 0 once all channels settle.
  - Goes to 1 the cycle after led_in changes while bypass=0.
- led_in is synchronous to clk (comes from the register); no synchronizer is required.
- Counters keep running regardless of led_in and bypass.

Test Plan (PWM_BITS=4, STEP_DIV=4, so max=15 and PWM period=15):
- Reset check: assert reset for 3 cycles with led_in=10'h3FF, then deassert. Required: led_out=0 and busy=0 during reset; bit0 level reaches 1 at the first step_tick (cycle 4 after release).
- Fade up: led_in=10'h001 held. Required: level0 steps every 4 cycles and saturates at 15 after 60 cycles; led_out[0] then stays constantly 1; busy falls the cycle after saturation; other bits stay 0.
- Fade down plus mid-ramp reversal: from level 15, set led_in=0 for 20 cycles (level 10), then set led_in=1. Required: level climbs 10→11 at the next tick with no jump; duty cycle is 11/15 measured over one PWM period.
- Duty check: hold a level at 5. Required: led_out high for exactly 5 of every 15 cycles, during pwm_cnt 0..4 (observed one cycle delayed).
- Bypass: mid-fade (level 7), assert bypass with led_in=10'h2AA. Required: led_out=10'h2AA one cycle later; busy=0 within 2 cycles. Deassert bypass with no led_in change: led_out for odd bits stays constantly 1 and busy stays 0.
- Async reset mid-fade: assert reset between clock edges while levels are 6. Required: led_out=0 immediately, without waiting for a clock edge; the fade restarts from 0 after release.
